// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin byte arbiter sharing one uart_tx between NUM_REQ requesters.
// Define UART_TX_ARB_PKT_LOCK_EN to keep multi-byte packets from being interleaved.
module uart_tx_arb #(
    parameter  int NUM_REQ      = 2,
    parameter  int BUSY_TIMEOUT = 16,
    localparam int GID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 send_en,
    output logic [7:0]           send_data,
    input  logic                 send_busy,
    output logic [GID_W-1:0]     grant_id,
    output logic                 timeout_err
);

    localparam int CNT_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    state_t             state, state_n;
    logic [GID_W-1:0]   last_grant;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] elig;
    logic [GID_W-1:0]   win;
    logic [7:0]         win_data;
    logic               found;
    logic               accept;
    logic               tmo;
    int                 idx;

`ifdef UART_TX_ARB_PKT_LOCK_EN
    logic             lock_vld;
    logic [GID_W-1:0] lock_id;

    // While locked only the owner may win, even if it is momentarily idle.
    always_comb begin
        elig = req_valid;
        if (lock_vld)
            elig = req_valid & (NUM_REQ'(1) << lock_id);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_id  <= '0;
        end else if (tmo) begin
            lock_vld <= 1'b0;
        end else if (accept) begin
            lock_vld <= !req_last[win];
            lock_id  <= win;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign elig = req_valid;
`endif

    // Round-robin search starting just after the previous winner.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        idx      = 0;
        win_data = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!found && elig[idx[GID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[GID_W-1:0];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == GID_W'(i))
                win_data = req_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = WAIT_HI;
            WAIT_HI: begin
                if (send_busy)          state_n = WAIT_LO;
                else if (cnt == TO_MAX) state_n = IDLE;
            end
            WAIT_LO: if (!send_busy) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        accept    = (state == IDLE) && !send_busy && found && !rst;
        tmo       = (state == WAIT_HI) && !send_busy && (cnt == TO_MAX);
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = accept && (win == GID_W'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            send_en     <= 1'b0;
            send_data   <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            last_grant  <= GID_W'(NUM_REQ - 1);
            cnt         <= '0;
        end else begin
            send_en     <= accept;
            timeout_err <= tmo;
            if (accept) begin
                send_data  <= win_data;
                grant_id   <= win;
                last_grant <= win;
                cnt        <= '0;
            end else if ((state == WAIT_HI) && !send_busy && !tmo) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed stimulus with a queue-based scoreboard for uart_tx_arb.
`timescale 1ns/1ps
module tb_uart_tx_arb;

    localparam int NR = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic          send_en;
    logic [7:0]    send_data;
    logic          send_busy;
    logic [0:0]    grant_id;
    logic          timeout_err;

    uart_tx_arb #(.NUM_REQ(NR), .BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .send_en(send_en), .send_data(send_data), .send_busy(send_busy),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    int en_cyc = -100;
    int to_cnt = 0;
    logic prev_en = 1'b0;
    logic busy_on = 1'b1;
    int busy_len = 10;

    logic [11:0] exp_q[$];
    logic [7:0]  tdat [NR][8];
    logic        tlast[NR][8];
    int          tp[NR];
    int          tn[NR];

    task automatic chk(string name, int act, int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < NR; i++) begin
            tp[i] = 0;
            tn[i] = 0;
        end
    endtask

    task automatic put(int r, logic [7:0] d, logic l);
        tdat[r][tn[r]]  = d;
        tlast[r][tn[r]] = l;
        tn[r]++;
    endtask

    task automatic ex(int g, logic [7:0] d);
        exp_q.push_back({4'(g), d});
    endtask

    task automatic wait_done(string name);
        int n;
        n = 0;
        while (n < 400 && (exp_q.size() != 0 || send_busy)) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_done"}, int'(n < 400), 1);
        repeat (25) @(posedge clk);
    endtask

    // Requester model: retires a byte when its send_en pulse is seen.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            if (send_en === 1'b1 && tp[grant_id] < tn[grant_id])
                tp[grant_id]++;
            for (int i = 0; i < NR; i++) begin
                req_valid[i] = tp[i] < tn[i];
                req_data[i*8 +: 8] = (tp[i] < tn[i]) ? tdat[i][tp[i]] : 8'h00;
                req_last[i] = (tp[i] < tn[i]) ? tlast[i][tp[i]] : 1'b0;
            end
        end
    end

    // uart_tx model: busy rises a cycle after send_en and holds busy_len cycles.
    initial begin
        send_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (send_en === 1'b1 && busy_on) begin
                @(negedge clk);
                send_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                send_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each send_en and checks handshake rules.
    initial begin
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst === 1'b0) begin
                if (send_en) begin
                    chk("en_width", int'(prev_en), 0);
                    chk("en_spacing", int'(cyc - en_cyc >= 3), 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_send", int'(send_data), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_id", int'(grant_id), int'(e[11:8]));
                        chk("send_data", int'(send_data), int'(e[7:0]));
                    end
                    en_cyc = cyc;
                end
                if (timeout_err) begin
                    to_cnt++;
                    chk("timeout_delay", cyc - en_cyc, TO);
                end
                if (req_ready != '0) begin
                    chk("ready_onehot", int'($onehot(req_ready)), 1);
                    chk("ready_while_busy", int'(send_busy), 0);
                    chk("ready_no_valid", int'((req_ready & ~req_valid) == '0), 1);
                end
            end
            prev_en = send_en;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_send_en", int'(send_en), 0);
        chk("rst_send_data", int'(send_data), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_timeout", int'(timeout_err), 0);
        chk("rst_ready", int'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;

        // single byte from requester 1
        @(posedge clk);
        ex(1, 8'h41);
        put(1, 8'h41, 1'b1);
        wait_done("t1");
        chk("t1_data_hold", int'(send_data), 'h41);
        chk("t1_gid_hold", int'(grant_id), 1);

        // both requesters continuously valid
        @(posedge clk);
        clr();
        for (int i = 0; i < 4; i++) begin
            put(0, 8'hA0, 1'b1);
            put(1, 8'hB0, 1'b1);
            ex(0, 8'hA0);
            ex(1, 8'hB0);
        end
        wait_done("t2");
        chk("t2_no_timeout", to_cnt, 0);

        // busy never rises: both bytes time out and are dropped
        @(posedge clk);
        busy_on = 1'b0;
        to_cnt = 0;
        clr();
        put(0, 8'h55, 1'b1);
        put(1, 8'h66, 1'b1);
        ex(0, 8'h55);
        ex(1, 8'h66);
        wait_done("t3");
        chk("t3_timeouts", to_cnt, 2);
        busy_on = 1'b1;

        // packet from requester 0 while requester 1 waits
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clr();
        put(0, 8'h10, 1'b0);
        put(0, 8'h11, 1'b0);
        put(0, 8'h12, 1'b1);
        put(1, 8'h20, 1'b1);
        put(1, 8'h21, 1'b1);
`ifdef UART_TX_ARB_PKT_LOCK_EN
        ex(0, 8'h10); ex(0, 8'h11); ex(0, 8'h12);
        ex(1, 8'h20); ex(1, 8'h21);
`else
        ex(0, 8'h10); ex(1, 8'h20); ex(0, 8'h11);
        ex(1, 8'h21); ex(0, 8'h12);
`endif
        wait_done("t4");

        // reset while a frame is in flight
        @(posedge clk);
        clr();
        put(1, 8'h31, 1'b1);
        ex(1, 8'h31);
        n = 0;
        while (!send_busy && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("t5_busy_seen", int'(send_busy), 1);
        repeat (2) @(posedge clk);
        put(0, 8'h70, 1'b1);
        put(1, 8'h32, 1'b1);
        ex(0, 8'h70);
        ex(1, 8'h32);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_send_en", int'(send_en), 0);
        chk("t5_send_data", int'(send_data), 0);
        chk("t5_grant_id", int'(grant_id), 0);
        chk("t5_timeout", int'(timeout_err), 0);
        chk("t5_ready", int'(req_ready), 0);
        chk("t5_busy_held", int'(send_busy), 1);
        @(negedge clk);
        rst = 1'b0;
        wait_done("t5");
        chk("t5_last_gid", int'(grant_id), 1);
        chk("t5_last_data", int'(send_data), 'h32);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` instance between `NUM_REQ` byte requesters, e.g. the fixed-string sender and the RX loopback echo path in `uart_top`. It accepts bytes over a valid/ready handshake. For each byte it issues a single-cycle `send_en` pulse to `uart_tx`, then tracks `send_busy` until the byte is fully shifted out. Only after that does it grant again.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `BUSY_TIMEOUT`, default 16: cycles to wait for `send_busy` to rise after `send_en` before abandoning the byte; must be ≥ 2.
- `GID_W`, localparam: `$clog2(NUM_REQ)`, minimum 1.
- `clk`, in, 1: system clock. The block has one clock.
- `rst`, in, 1: reset. Synchronous and active-high.
- `req_valid`, in, `NUM_REQ`: requester *i* has a byte.
- `req_data`, in, `NUM_REQ*8`: byte of requester *i* on bits `[i*8 +: 8]`.
- `req_last`, in, `NUM_REQ`: byte is the last of a packet. Used only with the lock feature.
- `req_ready`, out, `NUM_REQ`: one-hot. A byte transfers when valid and ready are both high.
- `send_en`, out, 1: to `uart_tx`; one-cycle pulse per byte.
- `send_data`, out, 8: to `uart_tx`; held stable from the `send_en` pulse until the next accept.
- `send_busy`, in, 1: from `uart_tx`.
- `grant_id`, out, `GID_W`: index of the requester owning the current or last byte.
- `timeout_err`, out, 1: one-cycle pulse when `BUSY_TIMEOUT` expires.

## Operation
- States: IDLE, WAIT_HI, WAIT_LO.
- **IDLE**
  - Entered when `send_busy`=0 and at least one eligible `req_valid` is high.
  - Winner: first valid index searching from `last_grant+1` upward, wrapping modulo `NUM_REQ`.
  - `req_ready[winner]`=1 combinationally in this cycle; all other ready bits are 0.
  - On the clock edge: `send_data` ← `req_data[winner]`; `send_en` ← 1; `grant_id` ← winner; `last_grant` ← winner; timeout counter cleared; go to WAIT_HI.
  - If `send_busy`=1 while in IDLE (foreign or leftover busy), all `req_ready`=0.
- **WAIT_HI**
  - `send_en` returns to 0, so it is exactly one cycle wide.
  - `send_busy`=1 → WAIT_LO.
  - Otherwise the counter increments. When the counter reaches `BUSY_TIMEOUT`-1: pulse `timeout_err`, go to IDLE. The byte is dropped, not retried.
- **WAIT_LO**
  - `send_busy`=0 → IDLE.
  - No timeout in this state; the frame length is owned by `uart_tx`.
- `req_ready` is 0 in WAIT_HI and WAIT_LO.
- Requesters may drop `req_valid` at any time before acceptance; a dropped request is never granted.
- Simultaneous valids: exactly one is served per byte. A requester that stays valid is served within `NUM_REQ` grants.
- Reset, including mid-frame:
  - State → IDLE.
  - `send_en`, `send_data`, `grant_id`, `timeout_err`, `req_ready` → 0.
  - `last_grant` → `NUM_REQ-1`, so requester 0 has first priority.
  - Lock is cleared.
  - A frame already in flight in `uart_tx` is not aborted. The arbiter then waits in IDLE while `send_busy`=1.

## Timing
- Accept at edge *k* (ready and valid high in cycle *k*-1) → `send_en`=1 and new `send_data` during cycle *k*.
- `send_busy` sampled high at the first edge of WAIT_HI → earliest WAIT_LO at *k*+1.
- Earliest next accept is in the cycle after `send_busy` is sampled low in WAIT_LO.
- Minimum spacing between `send_en` pulses: 3 cycles, plus the busy time.
- `grant_id` updates on the accept edge and is held until the next accept.
- `timeout_err` is high for the single cycle after the expiry edge.

## Configuration
- `UART_TX_ARB_PKT_LOCK_EN` **defined**:
  - Accepting a byte with `req_last`=0 sets the lock to the winner.
  - While locked, only the lock owner is eligible in IDLE. Others wait even if the owner is not valid.
  - Accepting a byte from the owner with `req_last`=1 clears the lock.
  - A timeout also clears the lock.
  - Use: a multi-byte string such as "你好  World\r\n" cannot be interleaved with echo bytes.
- `UART_TX_ARB_PKT_LOCK_EN` **undefined**:
  - `req_last` is ignored and no lock state exists.
  - Arbitration happens per byte.

## Test plan
- Reset, then requester 1 sends 0x41 with `send_busy` modelled as rising 1 cycle after `send_en` and staying high 10 cycles → one `send_en` pulse, `send_data`=0x41, `grant_id`=1, next `req_ready` no sooner than the cycle after busy falls.
- Both requesters valid continuously, 0xA0 and 0xB0, 4 bytes each → order 0,1,0,1,… on `grant_id`; `send_data` alternates 0xA0/0xB0.
- `send_busy` held at 0 after `send_en` → `timeout_err` pulses `BUSY_TIMEOUT` cycles after the pulse; byte dropped; next grant goes to the other valid requester.
- With the macro defined: requester 0 sends 3 bytes with `req_last`=0,0,1 while requester 1 is valid → all 3 bytes from requester 0 before any from requester 1. Without the macro: requester 1 is served after the first byte.
- Assert `rst` during WAIT_LO with `send_busy`=1 → outputs 0 on the next edge; no accept until `send_busy` falls; first grant then goes to requester 0.
